// File: rtl/fill_rect_addr_gen_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fill_rect_addr_gen_engine_if                                      |
// | Desc   : Framebuffer write bus (rts/rtr handshake, address, RGB444 pixel).  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
interface fill_rect_addr_gen_engine_if #(
   parameter int ADDR_W = 19
);
   logic              arb_rts;
   logic              arb_rtr;
   logic [ADDR_W-1:0] arb_addr;
   logic [11:0]       arb_data;

   modport master (output arb_rts, output arb_addr, output arb_data, input arb_rtr);
   modport slave  (input arb_rts, input arb_addr, input arb_data, output arb_rtr);
endinterface
`default_nettype wire

// File: rtl/fill_rect_addr_gen_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fill_rect_addr_gen_engine                                         |
// | Desc   : Row-major fill-rect pixel write generator; optional on-screen      |
// |          clipping enabled by defining FILL_RECT_CLIP_EN.                   |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module fill_rect_addr_gen_engine #(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int ADDR_W   = 19
) (
   input  logic        clk,
   input  logic        rst_,
   input  logic        addr_start_strobe,
   input  logic        cmd_fields_valid,
   input  logic [15:0] cmd_data_origx,
   input  logic [15:0] cmd_data_origy,
   input  logic [15:0] cmd_data_wid,
   input  logic [15:0] cmd_data_hgt,
   input  logic [3:0]  cmd_data_rval,
   input  logic [3:0]  cmd_data_gval,
   input  logic [3:0]  cmd_data_bval,
   fill_rect_addr_gen_engine_if.master arb,
   output logic        gen_busy,
   output logic        gen_done_strobe
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CALC = 3'd1,
      S_WAIT = 3'd2,
      S_GEN  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] c_pitch = ADDR_W'(SCREEN_W);

   state_t            r_state;
   logic [15:0]       r_origx, r_origy, r_wid, r_hgt, r_w, r_h, r_col, r_row;
   logic [11:0]       r_rgb;
   logic              r_fields_flag;
   logic [ADDR_W-1:0] r_row_base;
   logic [31:0]       w_base32;
   logic [15:0]       w_eff_w, w_eff_h;

`ifdef FILL_RECT_CLIP_EN
   logic              r_off_x, r_off_y;
   logic [15:0]       r_room_w, r_room_h;

   always_comb begin
      w_eff_w = r_off_x ? 16'd0 : ((r_wid < r_room_w) ? r_wid : r_room_w);
      w_eff_h = r_off_y ? 16'd0 : ((r_hgt < r_room_h) ? r_hgt : r_room_h);
   end

   // Bounds are registered in CALC so the clamp in WAIT is a short compare/select.
   always_ff @(posedge clk) begin
      if (rst_) begin
         r_off_x  <= 1'b0;
         r_off_y  <= 1'b0;
         r_room_w <= '0;
         r_room_h <= '0;
      end else if (r_state == S_CALC) begin
         r_off_x  <= (r_origx >= 16'(SCREEN_W));
         r_off_y  <= (r_origy >= 16'(SCREEN_H));
         r_room_w <= 16'(SCREEN_W) - r_origx;
         r_room_h <= 16'(SCREEN_H) - r_origy;
      end
   end
`else
   always_comb begin
      w_eff_w = r_wid;
      w_eff_h = r_hgt;
   end
`endif

   assign w_base32 = 32'(r_origy) * 32'(SCREEN_W) + 32'(r_origx);

   always_ff @(posedge clk) begin
      if (rst_) begin
         r_state         <= S_IDLE;
         r_origx         <= '0;
         r_origy         <= '0;
         r_wid           <= '0;
         r_hgt           <= '0;
         r_w             <= '0;
         r_h             <= '0;
         r_col           <= '0;
         r_row           <= '0;
         r_rgb           <= '0;
         r_fields_flag   <= 1'b0;
         r_row_base      <= '0;
         arb.arb_rts     <= 1'b0;
         arb.arb_addr    <= '0;
         arb.arb_data    <= '0;
         gen_busy        <= 1'b0;
         gen_done_strobe <= 1'b0;
      end else begin
         // Fields pulse may land while CALC is still busy; keep it sticky.
         if (cmd_fields_valid && r_state != S_DONE) begin
            r_fields_flag <= 1'b1;
            r_wid         <= cmd_data_wid;
            r_hgt         <= cmd_data_hgt;
            r_rgb         <= {cmd_data_rval, cmd_data_gval, cmd_data_bval};
         end
         case (r_state)
            S_IDLE: begin
               if (addr_start_strobe) begin
                  r_origx  <= cmd_data_origx;
                  r_origy  <= cmd_data_origy;
                  gen_busy <= 1'b1;
                  r_state  <= S_CALC;
               end
            end
            S_CALC: begin
               r_row_base <= w_base32[ADDR_W-1:0];
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               if (r_fields_flag) begin
                  r_w          <= w_eff_w;
                  r_h          <= w_eff_h;
                  r_col        <= '0;
                  r_row        <= '0;
                  arb.arb_data <= r_rgb;
                  if (w_eff_w == 16'd0 || w_eff_h == 16'd0) begin
                     gen_done_strobe <= 1'b1;
                     gen_busy        <= 1'b0;
                     r_state         <= S_DONE;
                  end else begin
                     arb.arb_addr <= r_row_base;
                     arb.arb_rts  <= 1'b1;
                     r_state      <= S_GEN;
                  end
               end
            end
            S_GEN: begin
               if (arb.arb_rts && arb.arb_rtr) begin
                  if (r_col != r_w - 16'd1) begin
                     r_col        <= r_col + 16'd1;
                     arb.arb_addr <= arb.arb_addr + ADDR_W'(1);
                  end else if (r_row != r_h - 16'd1) begin
                     r_col        <= '0;
                     r_row        <= r_row + 16'd1;
                     r_row_base   <= r_row_base + c_pitch;
                     arb.arb_addr <= r_row_base + c_pitch;
                  end else begin
                     arb.arb_rts     <= 1'b0;
                     gen_done_strobe <= 1'b1;
                     gen_busy        <= 1'b0;
                     r_state         <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               gen_done_strobe <= 1'b0;
               r_fields_flag   <= 1'b0;
               r_state         <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_fill_rect_addr_gen_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_fill_rect_addr_gen_engine                                      |
// | Desc   : Directed self-checking bench for fill_rect_addr_gen_engine.        |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_fill_rect_addr_gen_engine;
   logic        clk = 1'b0;
   logic        rst_;
   logic        addr_start_strobe, cmd_fields_valid;
   logic [15:0] cmd_data_origx, cmd_data_origy, cmd_data_wid, cmd_data_hgt;
   logic [3:0]  cmd_data_rval, cmd_data_gval, cmd_data_bval;
   logic        gen_busy, gen_done_strobe;

   fill_rect_addr_gen_engine_if #(.ADDR_W(19)) arb_if ();

   fill_rect_addr_gen_engine #(.SCREEN_W(640), .SCREEN_H(480), .ADDR_W(19)) dut (
      .clk               (clk),
      .rst_              (rst_),
      .addr_start_strobe (addr_start_strobe),
      .cmd_fields_valid  (cmd_fields_valid),
      .cmd_data_origx    (cmd_data_origx),
      .cmd_data_origy    (cmd_data_origy),
      .cmd_data_wid      (cmd_data_wid),
      .cmd_data_hgt      (cmd_data_hgt),
      .cmd_data_rval     (cmd_data_rval),
      .cmd_data_gval     (cmd_data_gval),
      .cmd_data_bval     (cmd_data_bval),
      .arb               (arb_if.master),
      .gen_busy          (gen_busy),
      .gen_done_strobe   (gen_done_strobe)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_q[$];
   int got_q[$];
   int done_n, done_c, first_rts;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // One command, observed for a fixed 40-cycle window; cycle 0 is the start negedge.
   task automatic run_cmd(input string name, input logic [15:0] ox, input logic [15:0] oy,
                          input logic [15:0] w, input logic [15:0] h, input logic [11:0] rgb,
                          input int toggle, input int restart_at, input int rst_at);
      logic        p_rts, p_rtr;
      logic [18:0] p_addr;
      logic [11:0] p_data;
      got_q.delete();
      done_n = 0; done_c = -1; first_rts = -1;
      p_rts = 1'b0; p_rtr = 1'b0; p_addr = '0; p_data = '0;
      @(negedge clk);
      addr_start_strobe = 1'b1; cmd_fields_valid = 1'b1;
      cmd_data_origx = ox; cmd_data_origy = oy; cmd_data_wid = w; cmd_data_hgt = h;
      {cmd_data_rval, cmd_data_gval, cmd_data_bval} = rgb;
      arb_if.arb_rtr = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         addr_start_strobe = 1'b0; cmd_fields_valid = 1'b0;
         if (rst_at > 0 && c == rst_at + 1) begin
            check({name, " rts after rst"}, 32'(arb_if.arb_rts), 32'd0);
            check({name, " busy after rst"}, 32'(gen_busy), 32'd0);
            rst_ = 1'b0;
         end
         if (c == 1) check({name, " busy after start"}, 32'(gen_busy), 32'd1);
         if (gen_done_strobe) begin
            done_n++; done_c = c;
            check({name, " busy at done"}, 32'(gen_busy), 32'd0);
         end
         if (arb_if.arb_rts && first_rts < 0) first_rts = c;
         if (p_rts && !p_rtr && rst_at == 0) begin
            check({name, " stall rts"}, 32'(arb_if.arb_rts), 32'd1);
            check({name, " stall addr"}, 32'(arb_if.arb_addr), 32'(p_addr));
            check({name, " stall data"}, 32'(arb_if.arb_data), 32'(p_data));
         end
         if (c == restart_at) begin
            addr_start_strobe = 1'b1; cmd_data_origx = 16'd100; cmd_data_origy = 16'd100;
         end
         if (c == rst_at) rst_ = 1'b1;
         arb_if.arb_rtr = (toggle != 0) ? (c % 2 == 0) : 1'b1;
         if (arb_if.arb_rts && arb_if.arb_rtr && rst_at == 0) begin
            got_q.push_back(int'(arb_if.arb_addr));
            check({name, " data"}, 32'(arb_if.arb_data), 32'(rgb));
         end
         p_rts = arb_if.arb_rts; p_rtr = arb_if.arb_rtr;
         p_addr = arb_if.arb_addr; p_data = arb_if.arb_data;
      end
      arb_if.arb_rtr = 1'b1;
      if (rst_at > 0) begin
         check({name, " no done after rst"}, 32'(done_n), 32'd0);
      end else begin
         check({name, " done count"}, 32'(done_n), 32'd1);
         check({name, " xfc count"}, 32'(got_q.size()), 32'(exp_q.size()));
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s addr[%0d]", name, i), 32'(got_q[i]), 32'(exp_q[i]));
         check({name, " idle busy"}, 32'(gen_busy), 32'd0);
      end
   endtask

   initial begin
      rst_ = 1'b1;
      addr_start_strobe = 1'b0; cmd_fields_valid = 1'b0;
      cmd_data_origx = '0; cmd_data_origy = '0; cmd_data_wid = '0; cmd_data_hgt = '0;
      cmd_data_rval = '0; cmd_data_gval = '0; cmd_data_bval = '0;
      arb_if.arb_rtr = 1'b1;
      repeat (3) @(negedge clk);
      check("reset rts", 32'(arb_if.arb_rts), 32'd0);
      check("reset addr", 32'(arb_if.arb_addr), 32'd0);
      check("reset data", 32'(arb_if.arb_data), 32'd0);
      check("reset busy", 32'(gen_busy), 32'd0);
      check("reset done", 32'(gen_done_strobe), 32'd0);
      rst_ = 1'b0;

      exp_q = '{641, 642, 1281, 1282};
      run_cmd("t1", 16'd1, 16'd1, 16'd2, 16'd2, 12'hF0A, 0, -1, 0);
      check("t1 first rts cycle", 32'(first_rts), 32'd3);
      check("t1 done cycle", 32'(done_c), 32'd7);

      run_cmd("t2", 16'd1, 16'd1, 16'd2, 16'd2, 12'hF0A, 1, -1, 0);

      exp_q = '{};
      run_cmd("t3", 16'd5, 16'd5, 16'd0, 16'd5, 12'h123, 0, -1, 0);
      check("t3 rts never high", 32'(first_rts), 32'hFFFF_FFFF);
      check("t3 done cycle", 32'(done_c), 32'd3);

      exp_q = '{1290, 1291, 1292, 1930, 1931, 1932};
      run_cmd("t4", 16'd10, 16'd2, 16'd3, 16'd2, 12'h5A5, 0, 5, 0);

`ifdef FILL_RECT_CLIP_EN
      exp_q = '{307198, 307199};
`else
      exp_q = '{307198, 307199, 307200, 307201, 307838, 307839, 307840, 307841,
                308478, 308479, 308480, 308481};
`endif
      run_cmd("t5", 16'd638, 16'd479, 16'd4, 16'd3, 12'h0F0, 0, -1, 0);

`ifdef FILL_RECT_CLIP_EN
      exp_q = '{};
`else
      exp_q = '{524287, 0};
`endif
      run_cmd("wrap", 16'd127, 16'd819, 16'd2, 16'd1, 12'hABC, 0, -1, 0);

      run_cmd("t6", 16'd1, 16'd1, 16'd2, 16'd2, 12'hF0A, 0, -1, 4);
      exp_q = '{641, 642, 1281, 1282};
      run_cmd("t6 after", 16'd1, 16'd1, 16'd2, 16'd2, 12'h777, 0, -1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
